// File: rtl/simmem_row_delay_tracker_if.sv
// Handshake bundle between the request source and the row-delay tracker.
//   in_*      : address request (valid/ready, address, ID, AXI AxLen)
//   release_* : delayed release of the request ID (valid/ready, ID)
// master: the requester / downstream bank side; slave: the tracker.
interface simmem_row_delay_tracker_if #(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned IdWidth   = 4
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [AddrWidth-1:0] in_addr_i;
  logic [IdWidth-1:0]   in_id_i;
  logic [7:0]           in_burst_len_i;
  logic                 release_valid_o;
  logic                 release_ready_i;
  logic [IdWidth-1:0]   release_id_o;

  modport master (
    output in_valid_i, in_addr_i, in_id_i, in_burst_len_i, release_ready_i,
    input  in_ready_o, release_valid_o, release_id_o
  );

  modport slave (
    input  in_valid_i, in_addr_i, in_id_i, in_burst_len_i, release_ready_i,
    output in_ready_o, release_valid_o, release_id_o
  );
endinterface

// File: rtl/simmem_row_delay_tracker.sv
// Single-bank DRAM row-buffer timing model for the simulated memory.
// Accepts one address request at a time, classifies it as row hit, row
// empty or row conflict, waits the modelled delay and then presents the
// request ID on the release handshake.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (slave)  : in_* request handshake, release_* ID handshake
//   hit_cnt_o    : saturating count of accepted row hits
//   miss_cnt_o   : saturating count of accepted empty/conflict requests
module simmem_row_delay_tracker #(
  parameter int unsigned AddrWidth         = 16,
  parameter int unsigned RowBufferLenWidth = 8,
  parameter int unsigned IdWidth           = 4,
  parameter int unsigned RowHitCost        = 10,
  parameter int unsigned PrechargeCost     = 50,
  parameter int unsigned ActivationCost    = 45,
  parameter int unsigned CntWidth          = 9,
  parameter int unsigned StatWidth         = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  simmem_row_delay_tracker_if.slave    bus,
  output logic [StatWidth-1:0]         hit_cnt_o,
  output logic [StatWidth-1:0]         miss_cnt_o
);

  localparam int unsigned RowWidth = AddrWidth - RowBufferLenWidth;

  localparam logic [CntWidth-1:0] CostHit      = CntWidth'(RowHitCost);
  localparam logic [CntWidth-1:0] CostEmpty    = CntWidth'(ActivationCost + RowHitCost);
  localparam logic [CntWidth-1:0] CostConflict =
    CntWidth'(PrechargeCost + ActivationCost + RowHitCost);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    RELEASE
  } state_e;

  state_e               state;
  logic [CntWidth-1:0]  cnt;
  logic [IdWidth-1:0]   id_q;
  logic [RowWidth-1:0]  open_row;
  logic                 row_open;

  logic [RowWidth-1:0]  req_row;
  logic                 is_hit;
  logic [CntWidth-1:0]  cost;
  logic [CntWidth-1:0]  delay;
  logic                 accept;

  // Column bits only select a word within the row; they carry no timing.
  logic                 unused_col_bits;
  assign unused_col_bits = ^bus.in_addr_i[RowBufferLenWidth-1:0];

  assign req_row = bus.in_addr_i[AddrWidth-1:RowBufferLenWidth];
  assign accept  = bus.in_valid_i && (state == IDLE);

  always_comb begin
    is_hit = 1'b0;
    cost   = CostEmpty;
    if (row_open) begin
      if (open_row == req_row) begin
        is_hit = 1'b1;
        cost   = CostHit;
      end else begin
        cost   = CostConflict;
      end
    end
    // One extra cycle per beat beyond the first.
    delay = cost + CntWidth'(bus.in_burst_len_i);
  end

  assign bus.in_ready_o      = (state == IDLE);
  assign bus.release_valid_o = (state == RELEASE);
  assign bus.release_id_o    = id_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      id_q       <= '0;
      open_row   <= '0;
      row_open   <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= delay - CntWidth'(1);
            id_q     <= bus.in_id_i;
            open_row <= req_row;
            row_open <= 1'b1;
            if (is_hit) begin
              if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + StatWidth'(1);
            end else begin
              if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + StatWidth'(1);
            end
            state <= COUNT;
          end
        end
        COUNT: begin
          if (cnt == '0) begin
            state <= RELEASE;
          end else begin
            cnt <= cnt - CntWidth'(1);
          end
        end
        RELEASE: begin
          if (bus.release_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simmem_row_delay_tracker.sv
module tb_simmem_row_delay_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  int          total = 0;
  int          bad   = 0;

  simmem_row_delay_tracker_if #(.AddrWidth(16), .IdWidth(4)) bus ();

  simmem_row_delay_tracker #(
    .AddrWidth(16), .RowBufferLenWidth(8), .IdWidth(4), .RowHitCost(10),
    .PrechargeCost(50), .ActivationCost(45), .CntWidth(9), .StatWidth(16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus.slave),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(bus.in_ready_o), 32'd1);
    check_eq({tag, "_rvalid"}, 32'(bus.release_valid_o), 32'd0);
    check_eq({tag, "_rid"}, 32'(bus.release_id_o), 32'd0);
    check_eq({tag, "_hit"}, 32'(hit_cnt), 32'd0);
    check_eq({tag, "_miss"}, 32'(miss_cnt), 32'd0);
  endtask

  // Accept one request, then count edges until release_valid rises.
  // Garbage with in_valid high is driven during COUNT to show it is ignored.
  task automatic issue(input string tag, input logic [15:0] addr, input logic [3:0] id,
                       input logic [7:0] len, input int exp_d);
    int n;
    check_eq({tag, "_ready_pre"}, 32'(bus.in_ready_o), 32'd1);
    bus.in_valid_i     = 1'b1;
    bus.in_addr_i      = addr;
    bus.in_id_i        = id;
    bus.in_burst_len_i = len;
    @(posedge clk); #1;
    bus.in_addr_i      = 16'hBEEF;
    bus.in_id_i        = ~id;
    bus.in_burst_len_i = 8'd200;
    check_eq({tag, "_ready_busy"}, 32'(bus.in_ready_o), 32'd0);
    n = 0;
    while (!bus.release_valid_o && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid_i = 1'b0;
    check_eq({tag, "_latency"}, 32'(n), 32'(exp_d));
    check_eq({tag, "_rid"}, 32'(bus.release_id_o), 32'(id));
  endtask

  task automatic do_release(input string tag);
    bus.release_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.release_ready_i = 1'b0;
    check_eq({tag, "_ready_after"}, 32'(bus.in_ready_o), 32'd1);
    check_eq({tag, "_rvalid_after"}, 32'(bus.release_valid_o), 32'd0);
  endtask

  initial begin
    bus.in_valid_i      = 1'b0;
    bus.in_addr_i       = '0;
    bus.in_id_i         = '0;
    bus.in_burst_len_i  = '0;
    bus.release_ready_i = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Empty row: 45 + 10.
    issue("empty", 16'h1234, 4'd3, 8'd0, 55);
    check_eq("empty_miss", 32'(miss_cnt), 32'd1);
    check_eq("empty_hit", 32'(hit_cnt), 32'd0);
    do_release("empty");

    // Same row 0x12: 10 + 2 beats.
    issue("hit", 16'h12FF, 4'd5, 8'd2, 12);
    check_eq("hit_hit", 32'(hit_cnt), 32'd1);
    check_eq("hit_miss", 32'(miss_cnt), 32'd1);
    do_release("hit");

    // Row 0x56 against open 0x12: 50 + 45 + 10.
    issue("conf", 16'h5600, 4'd7, 8'd0, 105);
    check_eq("conf_miss", 32'(miss_cnt), 32'd2);
    do_release("conf");

    // Conflict with longest burst: 105 + 255 = 360, then 20 cycles backpressure.
    issue("max", 16'h9900, 4'd9, 8'd255, 360);
    check_eq("max_miss", 32'(miss_cnt), 32'd3);
    check_eq("max_hit", 32'(hit_cnt), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check_eq("bp_rvalid", 32'(bus.release_valid_o), 32'd1);
      check_eq("bp_rid", 32'(bus.release_id_o), 32'd9);
      check_eq("bp_ready", 32'(bus.in_ready_o), 32'd0);
    end
    // New request arriving with the release handshake must wait a cycle.
    bus.in_valid_i     = 1'b1;
    bus.in_addr_i      = 16'h9955;
    bus.in_id_i        = 4'd11;
    bus.in_burst_len_i = 8'd100;
    bus.release_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.release_ready_i = 1'b0;
    bus.in_valid_i      = 1'b0;
    check_eq("bp_ready_after", 32'(bus.in_ready_o), 32'd1);
    check_eq("bp_not_taken", 32'(hit_cnt), 32'd1);

    // Hit on row 0x99 with 100 extra beats (110), reset 30 cycles in.
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    check_eq("mid_hit", 32'(hit_cnt), 32'd2);
    for (int i = 0; i < 29; i++) begin
      @(posedge clk); #1;
    end
    check_eq("mid_counting", 32'(bus.release_valid_o), 32'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Row 0x99 was open before reset; now it must be classified empty.
    issue("after_rst", 16'h9900, 4'd2, 8'd0, 55);
    check_eq("after_rst_miss", 32'(miss_cnt), 32'd1);
    check_eq("after_rst_hit", 32'(hit_cnt), 32'd0);
    do_release("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
